// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, column drive
// patterns, hex key map and index helpers.
package keypad_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int ROW_IDX_W = $clog2(NUM_ROWS);
  localparam int COL_IDX_W = $clog2(NUM_COLS);

  typedef logic [ROW_IDX_W-1:0] row_idx_t;
  typedef logic [COL_IDX_W-1:0] col_idx_t;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Active-low one-hot column drive, indexed by column number.
  localparam logic [NUM_COLS-1:0][NUM_COLS-1:0] COL_ONEHOT = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // KEY_MAP[row][col]; each row literal lists col3..col0.
  localparam logic [NUM_ROWS-1:0][NUM_COLS-1:0][3:0] KEY_MAP = {
    {4'hD, 4'hF, 4'h0, 4'hE},
    {4'hC, 4'h9, 4'h8, 4'h7},
    {4'hB, 4'h6, 4'h5, 4'h4},
    {4'hA, 4'h3, 4'h2, 4'h1}
  };

  function automatic logic [3:0] key_lookup(input row_idx_t r, input col_idx_t c);
    return KEY_MAP[r][c];
  endfunction

  // Lowest-numbered low row; callers only use it when at least one row is low.
  function automatic row_idx_t lowest_low(input logic [NUM_ROWS-1:0] r);
    row_idx_t idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = row_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, hex encode with one-cycle strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 48000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_SCANS   = 500
) (
  input  logic       int_osc,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SCANS - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_chk
    $error("keypad_scanner: SCAN_DIV must be >= 2, scan counts >= 1");
  end

  logic [NUM_ROWS-1:0] rows_s;

  sync_2ff #(
    .WIDTH  (NUM_ROWS),
    .RST_VAL(4'hF)
  ) u_row_sync (
    .clk_i (int_osc),
    .rst_ni(reset_n),
    .d_i   (rows),
    .q_o   (rows_s)
  );

  // Slot divider: tick marks the last cycle of each column slot.
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge int_osc or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

  state_e              state_q;
  col_idx_t            col_q;
  col_idx_t            col_nxt;
  row_idx_t            row_q;
  logic [DB_W-1:0]     dbc_q;
  logic [NUM_COLS-1:0] cols_q;
  logic [3:0]          key_q;
  logic                valid_q;
  logic                held_q;
  logic                cand_low;

  assign col_nxt  = col_q + col_idx_t'(1);
  assign cand_low = ~rows_s[row_q];

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_q;
`endif

  // col_q doubles as the latched candidate column: it only moves in SCAN.
  always_ff @(posedge int_osc or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      col_q   <= '0;
      cols_q  <= COL_ONEHOT[0];
      row_q   <= '0;
      dbc_q   <= '0;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (&rows_s) begin
              col_q  <= col_nxt;
              cols_q <= COL_ONEHOT[col_nxt];
            end else begin
              row_q   <= lowest_low(rows_s);
              dbc_q   <= '0;
              state_q <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (cand_low) begin
              if (dbc_q == DB_LAST) begin
                key_q   <= key_lookup(row_q, col_q);
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                dbc_q   <= '0;
                state_q <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_q   <= '0;
`endif
              end else begin
                dbc_q <= dbc_q + DB_W'(1);
              end
            end else begin
              dbc_q   <= '0;
              state_q <= SCAN;
              col_q   <= col_nxt;
              cols_q  <= COL_ONEHOT[col_nxt];
            end
          end
          HELD: begin
            if (!cand_low) begin
              if (dbc_q == DB_LAST) begin
                held_q  <= 1'b0;
                dbc_q   <= '0;
                state_q <= SCAN;
                col_q   <= col_nxt;
                cols_q  <= COL_ONEHOT[col_nxt];
              end else begin
                dbc_q <= dbc_q + DB_W'(1);
              end
            end else begin
              dbc_q <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (rep_q == REP_LAST) begin
                rep_q   <= '0;
                valid_q <= 1'b1;
              end else begin
                rep_q <= rep_q + REP_W'(1);
              end
`endif
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
